pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central pipeline control unit. Collects per-stage stall requests and exception/ertn requests and drives the `pause[5:0]` vector and `exception_flush` pulse that every inter-stage register (pc, if_id, id_ex, ex_mem, mem_wb) consumes. It also supplies the redirect PC to the fetch stage.

An exception raised while MEM is stalled is held in a pending state and fires once the stall clears. After each flush, a short hold window masks new exception requests.

## Interface
- `HOLD_CYCLES`, default 2: number of cycles after a flush during which `exception_req` is ignored (1..15).
- `WDOG_LIMIT`, default 1024: consecutive non-zero-pause cycles that trip the watchdog (only used with the macro).
- `clk` input 1: pipeline clock.
- `rst` input 1: reset, asynchronous, active-low.
- `stall_req_if` input 1: fetch stage needs to stall.
- `stall_req_id` input 1: decode stall (load-use, CSR hazard).
- `stall_req_ex` input 1: execute stall (multi-cycle div/mul).
- `stall_req_mem` input 1: memory stage stall (outstanding access).
- `exception_req` input 1: MEM/CSR reports an exception or ertn this cycle.
- `is_ertn` input 1: qualifies `exception_req` as ertn.
- `eentry_pc` input 32: exception entry target.
- `era_pc` input 32: ertn return target.
- `pause` output 6: stall vector. Bit 0 = pc, 1 = if_id, 2 = id_ex, 3 = ex_mem, 4 = mem_wb, 5 = wb.
- `exception_flush` output 1: one-cycle flush pulse to all pipeline registers.
- `new_pc` output 32: redirect target, valid only while `exception_flush` = 1, else 32'h0.
- `stall_timeout` output 1: sticky watchdog flag.

## Operation
- Pause encoding is a priority encoder; the highest requesting stage wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- Target select: `is_ertn` ? `era_pc` : `eentry_pc`.
- FSM states are RUN, PENDING and HOLD. Reset state is RUN.
- RUN, `exception_req` && !`stall_req_mem`: assert `exception_flush` and output `new_pc` = target in the same cycle. Force `pause` = 0 that cycle. Load the hold counter with `HOLD_CYCLES` and go to HOLD.
- RUN, `exception_req` && `stall_req_mem`: no flush. Register the target into `pend_pc`; `pause` follows stall requests. Go to PENDING.
- PENDING: `pause` follows stall requests and further `exception_req` is ignored. When `stall_req_mem` = 0: flush with `new_pc` = `pend_pc`, `pause` = 0, load the counter and go to HOLD.
- HOLD: `pause` follows stall requests and `exception_req` is ignored. The counter decrements each cycle; when it reaches 0, return to RUN. The request is re-evaluated in RUN on the following cycle.
- Flush overrides every stall request in the same cycle, except the PENDING deferral rule.
- Reset mid-operation (`rst` low, asynchronous):
  - State → RUN; counter and `pend_pc` → 0.
  - All outputs → 0 immediately: `pause` 6'b0, `exception_flush` 0, `new_pc` 32'h0, `stall_timeout` 0.

## Timing
- Stall to `pause`: combinational, 0-cycle latency. Stages sample `pause` at the same clock edge.
- Unblocked exception: flush in the same cycle as `exception_req`.
- Deferred exception: flush in the first cycle in which `stall_req_mem` is low.
- `exception_flush` is never high for two consecutive cycles.
- A minimum of `HOLD_CYCLES` cycles separates two flushes.
- All registers update on posedge `clk`.

## Configuration
- Macro: `PIPE_STALL_WATCHDOG_EN`.
- Defined:
  - A counter increments each cycle `pause` != 0 and clears when `pause` = 0 or a flush occurs.
  - When the count reaches `WDOG_LIMIT`, `stall_timeout` sets and stays high until reset.
  - The counter saturates at `WDOG_LIMIT`.
- Undefined: no counter logic; `stall_timeout` tied to 0.

## Structure
- Shared defines in `define.v`:
  - `PauseWidth` (5:0).
  - State encodings `CTRL_RUN`, `CTRL_PENDING`, `CTRL_HOLD`.
  - Pause constants `PAUSE_NONE`, `PAUSE_IF`, `PAUSE_ID`, `PAUSE_EX`, `PAUSE_MEM`.
- Sub-module `stall_watchdog` (counter + sticky flag), instantiated only under the macro.

## Test plan
- `stall_req_ex` = 1 and `stall_req_id` = 1 for 3 cycles → `pause` = 6'b001111 each cycle. Then 6'b000000 when both drop.
- RUN: `exception_req` = 1, `is_ertn` = 0, `eentry_pc` = 32'h1c00_8000 → same cycle `exception_flush` = 1, `new_pc` = 32'h1c00_8000, `pause` = 0. Next cycle `exception_flush` = 0.
- `exception_req` + `stall_req_mem` held 4 cycles, `era_pc` = 32'h1c00_0040 with `is_ertn` = 1:
  - No flush and `pause` = 6'b011111 for those cycles.
  - Flush with `new_pc` = 32'h1c00_0040 in the cycle `stall_req_mem` drops, even if `era_pc` has since changed.
- Flush, then `exception_req` held high → no second flush for 2 cycles (`HOLD_CYCLES` = 2). Second flush on the 4th cycle after the first.
- `rst` pulled low while in PENDING → outputs 0 immediately. After release, state is RUN and no flush occurs without a new request.
- With `PIPE_STALL_WATCHDOG_EN` and `WDOG_LIMIT` = 8:
  - `stall_req_if` held 8 cycles → `stall_timeout` = 1 and stays high after the stall ends.
  - Held only 7 cycles → remains 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// Pause vectors map bit 0..5 to pc, if_id, id_ex, ex_mem, mem_wb, wb.
package pipeline_ctrl_pkg;

   localparam int PAUSE_W = 6;
   localparam int HOLD_CNT_W = 4;

   typedef logic [PAUSE_W-1:0] pause_t;

   typedef enum logic [1:0] {
      CTRL_RUN     = 2'd0,
      CTRL_PENDING = 2'd1,
      CTRL_HOLD    = 2'd2
   } ctrl_state_e;

   localparam pause_t PAUSE_NONE = 6'b000000;
   localparam pause_t PAUSE_IF   = 6'b000011;
   localparam pause_t PAUSE_ID   = 6'b000111;
   localparam pause_t PAUSE_EX   = 6'b001111;
   localparam pause_t PAUSE_MEM  = 6'b011111;

   // The deepest requesting stage freezes itself and everything upstream.
   function automatic pause_t encode_pause(input logic s_if, input logic s_id,
                                           input logic s_ex, input logic s_mem);
      pause_t p;
      if (s_mem)     p = PAUSE_MEM;
      else if (s_ex) p = PAUSE_EX;
      else if (s_id) p = PAUSE_ID;
      else if (s_if) p = PAUSE_IF;
      else           p = PAUSE_NONE;
      return p;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request/response bundle between the pipeline stages (master) and the
// control unit (slave).
interface pipeline_ctrl_if;
   import pipeline_ctrl_pkg::*;

   logic        stall_req_if;
   logic        stall_req_id;
   logic        stall_req_ex;
   logic        stall_req_mem;
   logic        exception_req;
   logic        is_ertn;
   logic [31:0] eentry_pc;
   logic [31:0] era_pc;
   pause_t      pause;
   logic        exception_flush;
   logic [31:0] new_pc;
   logic        stall_timeout;

   modport master (
      output stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
      output exception_req, is_ertn, eentry_pc, era_pc,
      input  pause, exception_flush, new_pc, stall_timeout
   );

   modport slave (
      input  stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
      input  exception_req, is_ertn, eentry_pc, era_pc,
      output pause, exception_flush, new_pc, stall_timeout
   );
endinterface

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// stall_watchdog: counts consecutive paused cycles and raises a sticky flag
// once the count reaches LIMIT. Only instantiated with PIPE_STALL_WATCHDOG_EN.
module stall_watchdog #(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic stall_active,
   input  logic flush,
   output logic timeout
);
   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

   logic [W-1:0] cnt_q, cnt_d;
   logic         timeout_q, timeout_d;

   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (!stall_active || flush) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT_V) begin
         cnt_d = cnt_q + W'(1);
      end
      if (cnt_d == LIMIT_V) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall priority encoding, exception/ertn flush sequencing and
// redirect PC. Optional stall watchdog enabled by PIPE_STALL_WATCHDOG_EN.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int HOLD_CYCLES = 2,
   parameter int WDOG_LIMIT  = 1024
) (
   input  logic            clk,
   input  logic            rst,
   pipeline_ctrl_if.slave  bus
);
   localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES);

   ctrl_state_e             state_q, state_d;
   logic [HOLD_CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]             pend_pc_q, pend_pc_d;

   pause_t      stall_pause;
   pause_t      pause_c;
   logic        flush_c;
   logic [31:0] new_pc_c;
   logic [31:0] target_pc;

   assign stall_pause = encode_pause(bus.stall_req_if, bus.stall_req_id,
                                     bus.stall_req_ex, bus.stall_req_mem);
   assign target_pc   = bus.is_ertn ? bus.era_pc : bus.eentry_pc;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_pc_d = pend_pc_q;
      flush_c   = 1'b0;
      new_pc_c  = 32'h0;
      pause_c   = stall_pause;
      case (state_q)
         CTRL_RUN: begin
            if (bus.exception_req) begin
               if (!bus.stall_req_mem) begin
                  flush_c  = 1'b1;
                  new_pc_c = target_pc;
                  pause_c  = PAUSE_NONE;
                  cnt_d    = HOLD_LOAD;
                  state_d  = CTRL_HOLD;
               end else begin
                  // MEM still owns an access; capture the target now so a
                  // later change on era/eentry cannot retarget the flush.
                  pend_pc_d = target_pc;
                  state_d   = CTRL_PENDING;
               end
            end
         end
         CTRL_PENDING: begin
            if (!bus.stall_req_mem) begin
               flush_c  = 1'b1;
               new_pc_c = pend_pc_q;
               pause_c  = PAUSE_NONE;
               cnt_d    = HOLD_LOAD;
               state_d  = CTRL_HOLD;
            end
         end
         CTRL_HOLD: begin
            if (cnt_q == '0) begin
               state_d = CTRL_RUN;
            end else begin
               cnt_d = cnt_q - HOLD_CNT_W'(1);
            end
         end
         default: state_d = CTRL_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= CTRL_RUN;
         cnt_q     <= '0;
         pend_pc_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   // Outputs are combinational from the requests, so reset gates them too.
   assign bus.pause           = rst ? pause_c  : PAUSE_NONE;
   assign bus.exception_flush = rst ? flush_c  : 1'b0;
   assign bus.new_pc          = rst ? new_pc_c : 32'h0;

`ifdef PIPE_STALL_WATCHDOG_EN
   logic timeout_w;

   stall_watchdog #(
      .LIMIT (WDOG_LIMIT)
   ) u_stall_watchdog (
      .clk          (clk),
      .rst          (rst),
      .stall_active (pause_c != PAUSE_NONE),
      .flush        (flush_c),
      .timeout      (timeout_w)
   );

   assign bus.stall_timeout = timeout_w;
`else
   assign bus.stall_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each step pushes hand-derived expected
// outputs and pops/compares them at the following negedge.
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipeline_ctrl_if bus ();

   pipeline_ctrl #(
      .HOLD_CYCLES (2),
      .WDOG_LIMIT  (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef PIPE_STALL_WATCHDOG_EN
   localparam logic WD = 1'b1;
`else
   localparam logic WD = 1'b0;
`endif

   typedef struct {
      logic [5:0]  pause;
      logic        flush;
      logic [31:0] pc;
      logic        to;
   } exp_t;

   exp_t sb_q[$];
   int   checks_cnt = 0;
   int   fail_cnt   = 0;
   int   txn_cnt    = 0;

   localparam logic [3:0] S_NONE = 4'b0000; // {mem, ex, id, if}
   localparam logic [3:0] S_IF   = 4'b0001;
   localparam logic [3:0] S_ID   = 4'b0010;
   localparam logic [3:0] S_IDEX = 4'b0110;
   localparam logic [3:0] S_MEM  = 4'b1000;
   localparam logic [3:0] S_MIF  = 4'b1001;
   localparam logic [3:0] S_EX   = 4'b0100;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] st, input logic exc, input logic ertn,
                        input logic [31:0] ee, input logic [31:0] era);
      bus.stall_req_if  = st[0];
      bus.stall_req_id  = st[1];
      bus.stall_req_ex  = st[2];
      bus.stall_req_mem = st[3];
      bus.exception_req = exc;
      bus.is_ertn       = ertn;
      bus.eentry_pc     = ee;
      bus.era_pc        = era;
   endtask

   task automatic step(input string tag, input logic [3:0] st, input logic exc,
                       input logic ertn, input logic [31:0] ee, input logic [31:0] era,
                       input logic [5:0] e_pause, input logic e_flush,
                       input logic [31:0] e_pc, input logic e_to);
      exp_t e;
      drive(st, exc, ertn, ee, era);
      sb_q.push_back('{pause: e_pause, flush: e_flush, pc: e_pc, to: e_to});
      @(negedge clk);
      e = sb_q.pop_front();
      txn_cnt++;
      $display("txn %0d %s: pause=%b flush=%b new_pc=%h timeout=%b", txn_cnt, tag,
               bus.pause, bus.exception_flush, bus.new_pc, bus.stall_timeout);
      check({tag, ".pause"}, 32'(bus.pause), 32'(e.pause));
      check({tag, ".flush"}, 32'(bus.exception_flush), 32'(e.flush));
      check({tag, ".new_pc"}, bus.new_pc, e.pc);
      check({tag, ".timeout"}, 32'(bus.stall_timeout), 32'(e.to));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         step(tag, S_NONE, 1'b0, 1'b0, 32'h0, 32'h0, PAUSE_NONE, 1'b0, 32'h0, 1'b0);
      end
   endtask

   initial begin
      // reset asserted with every request high: outputs must still be zero
      drive(4'b1111, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222);
      #3;
      check("rst.pause", 32'(bus.pause), 32'h0);
      check("rst.flush", 32'(bus.exception_flush), 32'h0);
      check("rst.new_pc", bus.new_pc, 32'h0);
      check("rst.timeout", 32'(bus.stall_timeout), 32'h0);
      drive(S_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
      #4 rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 3; i++)
         step("idex", S_IDEX, 1'b0, 1'b0, 32'h0, 32'h0, PAUSE_EX, 1'b0, 32'h0, 1'b0);
      idle("idex_drop", 1);

      step("if", S_IF, 1'b0, 1'b0, 32'h0, 32'h0, PAUSE_IF, 1'b0, 32'h0, 1'b0);
      step("id", S_ID, 1'b0, 1'b0, 32'h0, 32'h0, PAUSE_ID, 1'b0, 32'h0, 1'b0);
      step("memif", S_MIF, 1'b0, 1'b0, 32'h0, 32'h0, PAUSE_MEM, 1'b0, 32'h0, 1'b0);
      idle("idle", 1);

      // unblocked exception overrides id/ex stall
      step("exc", S_IDEX, 1'b1, 1'b0, 32'h1c00_8000, 32'hdead_0000, PAUSE_NONE, 1'b1, 32'h1c00_8000, 1'b0);
      idle("exc_after", 3);

      // deferred ertn behind a MEM stall
      for (int i = 0; i < 4; i++)
         step("defer", S_MEM, 1'b1, 1'b1, 32'h0, 32'h1c00_0040, PAUSE_MEM, 1'b0, 32'h0, 1'b0);
      step("defer_fire", S_NONE, 1'b0, 1'b1, 32'h0, 32'hdead_beef, PAUSE_NONE, 1'b1, 32'h1c00_0040, 1'b0);
      idle("defer_after", 3);

      // exception held: hold window masks it, second flush 4 cycles later
      step("hold0", S_NONE, 1'b1, 1'b0, 32'h1c00_9000, 32'h0, PAUSE_NONE, 1'b1, 32'h1c00_9000, 1'b0);
      step("hold1", S_NONE, 1'b1, 1'b0, 32'h1c00_9000, 32'h0, PAUSE_NONE, 1'b0, 32'h0, 1'b0);
      step("hold2", S_EX, 1'b1, 1'b0, 32'h1c00_9000, 32'h0, PAUSE_EX, 1'b0, 32'h0, 1'b0);
      step("hold3", S_NONE, 1'b1, 1'b0, 32'h1c00_9000, 32'h0, PAUSE_NONE, 1'b0, 32'h0, 1'b0);
      step("hold4", S_NONE, 1'b1, 1'b0, 32'h1c00_9000, 32'h0, PAUSE_NONE, 1'b1, 32'h1c00_9000, 1'b0);
      idle("hold_after", 3);

      // reset while PENDING
      step("pend0", S_MEM, 1'b1, 1'b0, 32'h1c00_a000, 32'h0, PAUSE_MEM, 1'b0, 32'h0, 1'b0);
      step("pend1", S_MEM, 1'b0, 1'b0, 32'h1c00_a000, 32'h0, PAUSE_MEM, 1'b0, 32'h0, 1'b0);
      rst = 1'b0;
      #1;
      check("pend_rst.pause", 32'(bus.pause), 32'h0);
      check("pend_rst.flush", 32'(bus.exception_flush), 32'h0);
      check("pend_rst.new_pc", bus.new_pc, 32'h0);
      check("pend_rst.timeout", 32'(bus.stall_timeout), 32'h0);
      #2 rst = 1'b1;
      step("post_rst", S_NONE, 1'b0, 1'b0, 32'h1c00_a000, 32'h0, PAUSE_NONE, 1'b0, 32'h0, 1'b0);
      idle("post_rst_idle", 2);

      // watchdog: 7 paused cycles stays clear, 8 sets the sticky flag
      for (int i = 0; i < 7; i++)
         step("wd7", S_IF, 1'b0, 1'b0, 32'h0, 32'h0, PAUSE_IF, 1'b0, 32'h0, 1'b0);
      idle("wd7_end", 1);
      for (int i = 0; i < 8; i++)
         step("wd8", S_IF, 1'b0, 1'b0, 32'h0, 32'h0, PAUSE_IF, 1'b0, 32'h0, 1'b0);
      step("wd8_end0", S_NONE, 1'b0, 1'b0, 32'h0, 32'h0, PAUSE_NONE, 1'b0, 32'h0, WD);
      step("wd8_end1", S_NONE, 1'b0, 1'b0, 32'h0, 32'h0, PAUSE_NONE, 1'b0, 32'h0, WD);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end
endmodule
